// File: rtl/round_timer_pkg.sv
// Shared definitions for round timing: state codes, game-wide defaults and
// two-digit BCD helpers used by the round timer and its neighbours.
package round_timer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_OVER   = 3'd4
    } round_state_t;

    // Defaults shared with the clock divider and the game logic.
    localparam int DEF_TICKS_PER_SEC = 50;
    localparam int DEF_ROUND_SECONDS = 60;
    localparam int DEF_PRE_ROUND     = 3;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    function automatic bcd2_t to_bcd2(input int unsigned value);
        bcd2_t r;
        r.tens = 4'((value / 32'd10) % 32'd10);
        r.ones = 4'(value % 32'd10);
        return r;
    endfunction

endpackage

// File: rtl/round_timer_tick_edge_detect.sv
// Rising-edge detector for the divider's game_tick square wave; emits a
// registered one-cycle strobe per rising edge.
module tick_edge_detect (
    input  logic clk_100mhz,
    input  logic reset,
    input  logic in,
    output logic pulse
);

    logic tick_d_r;

    // History register starts low, so a level already high at reset release
    // is taken as the first tick.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            tick_d_r <= 1'b0;
            pulse    <= 1'b0;
        end else begin
            tick_d_r <= in;
            pulse    <= in & ~tick_d_r;
        end
    end

endmodule

// File: rtl/round_timer.sv
// Round-control timer: prescales game ticks into seconds and sequences
// idle / pre-round countdown / play / paused / game over with BCD digits.
module round_timer
    import round_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int ROUND_SECONDS = DEF_ROUND_SECONDS,
    parameter int PRE_ROUND     = DEF_PRE_ROUND
) (
    input  logic               clk_100mhz,
    input  logic               reset,
    input  logic               game_tick,
    input  logic               start,
    input  logic               pause,
    output logic               tick_pulse,
    output logic [STATE_W-1:0] state,
    output logic [3:0]         sec_tens,
    output logic [3:0]         sec_ones,
    output logic               playing,
    output logic               time_up
);

    localparam int          SUB_W      = $clog2(TICKS_PER_SEC);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
    localparam logic [SUB_W-1:0] SUB_ZERO = {SUB_W{1'b0}};
    localparam logic [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
    localparam bcd2_t       ROUND_BCD  = to_bcd2(ROUND_SECONDS);
    localparam bcd2_t       PRE_BCD    = to_bcd2(PRE_ROUND);
    localparam bcd2_t       BCD_ONE    = {4'd0, 4'd1};
    localparam bcd2_t       BCD_ZERO   = {4'd0, 4'd0};

    round_state_t     state_r;
    bcd2_t            digits_r;
    logic [SUB_W-1:0] sub_r;
    logic             playing_r;
    logic             time_up_r;
    logic             tick_pulse_s;
    logic             sec_evt_s;

    function automatic bcd2_t bcd_dec(input bcd2_t d);
        bcd2_t r;
        if (d.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = d.tens - 4'd1;
        end else begin
            r.ones = d.ones - 4'd1;
            r.tens = d.tens;
        end
        return r;
    endfunction

    tick_edge_detect u_tick_edge (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .in         (game_tick),
        .pulse      (tick_pulse_s)
    );

    assign sec_evt_s = tick_pulse_s && (sub_r == SUB_LAST);

    // Round FSM with the seconds prescaler and display digits.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            digits_r  <= ROUND_BCD;
            sub_r     <= SUB_ZERO;
            playing_r <= 1'b0;
            time_up_r <= 1'b0;
        end else begin
            time_up_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    playing_r <= 1'b0;
                    if (start) begin
                        state_r  <= ST_READY;
                        digits_r <= PRE_BCD;
                        sub_r    <= SUB_ZERO;
                    end else begin
                        digits_r <= ROUND_BCD;
                    end
                end
                ST_READY: begin
                    if (sec_evt_s) begin
                        sub_r <= SUB_ZERO;
                        if (digits_r.ones == 4'd1) begin
                            state_r   <= ST_PLAY;
                            digits_r  <= ROUND_BCD;
                            playing_r <= 1'b1;
                        end else begin
                            digits_r.ones <= digits_r.ones - 4'd1;
                        end
                    end else if (tick_pulse_s) begin
                        sub_r <= sub_r + SUB_ONE;
                    end else begin
                        sub_r <= sub_r;
                    end
                end
                ST_PLAY: begin
                    // Expiry beats pause; a non-expiring second still counts down.
                    if (sec_evt_s) begin
                        sub_r <= SUB_ZERO;
                        if (digits_r == BCD_ONE) begin
                            state_r   <= ST_OVER;
                            digits_r  <= BCD_ZERO;
                            playing_r <= 1'b0;
                            time_up_r <= 1'b1;
                        end else begin
                            digits_r <= bcd_dec(digits_r);
                            if (pause) begin
                                state_r   <= ST_PAUSED;
                                playing_r <= 1'b0;
                            end else begin
                                playing_r <= 1'b1;
                            end
                        end
                    end else begin
                        if (tick_pulse_s) begin
                            sub_r <= sub_r + SUB_ONE;
                        end else begin
                            sub_r <= sub_r;
                        end
                        if (pause) begin
                            state_r   <= ST_PAUSED;
                            playing_r <= 1'b0;
                        end else begin
                            playing_r <= 1'b1;
                        end
                    end
                end
                ST_PAUSED: begin
                    // Sub-counter is held so the partial second resumes.
                    if (!pause) begin
                        state_r   <= ST_PLAY;
                        playing_r <= 1'b1;
                    end else begin
                        playing_r <= 1'b0;
                    end
                end
                ST_OVER: begin
                    playing_r <= 1'b0;
                    if (start) begin
                        state_r  <= ST_READY;
                        digits_r <= PRE_BCD;
                        sub_r    <= SUB_ZERO;
                    end else begin
                        digits_r <= BCD_ZERO;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    digits_r  <= ROUND_BCD;
                    sub_r     <= SUB_ZERO;
                    playing_r <= 1'b0;
                end
            endcase
        end
    end

    assign tick_pulse = tick_pulse_s;
    assign state      = state_r;
    assign sec_tens   = digits_r.tens;
    assign sec_ones   = digits_r.ones;
    assign playing    = playing_r;
    assign time_up    = time_up_r;

endmodule

// File: tb/tb_round_timer.sv
// Scoreboard bench for round_timer: stimulus queues expected display records,
// a monitor pops one each time the visible round status changes.
module tb_round_timer;

    localparam int TPS = 4;
    localparam int RS  = 12;
    localparam int PRE = 3;

    logic       clk_100mhz = 1'b0;
    logic       reset;
    logic       game_tick;
    logic       start;
    logic       pause;
    logic       tick_pulse;
    logic [2:0] state;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       playing;
    logic       time_up;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       play;
        logic       tup;
    } obs_t;

    obs_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    bit   gen_en     = 1'b0;
    bit   hold_val   = 1'b1;
    bit   mon_en     = 1'b0;
    int   ticks_seen = 0;

    round_timer #(
        .TICKS_PER_SEC (TPS),
        .ROUND_SECONDS (RS),
        .PRE_ROUND     (PRE)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .game_tick  (game_tick),
        .start      (start),
        .pause      (pause),
        .tick_pulse (tick_pulse),
        .state      (state),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .playing    (playing),
        .time_up    (time_up)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // game_tick: 10-cycle square wave (low 5, high 5) when enabled.
    initial begin
        int   ph;
        logic nv;
        ph = 0;
        game_tick = 1'b1;
        forever begin
            @(posedge clk_100mhz);
            #1;
            if (gen_en) begin
                nv = (ph >= 5);
                if (nv && !game_tick) ticks_seen++;
                game_tick = nv;
                ph = (ph == 9) ? 0 : ph + 1;
            end else begin
                game_tick = hold_val;
                ph = 0;
            end
        end
    end

    // Monitor: every change of the visible status pops one expected record.
    initial begin
        obs_t cur;
        obs_t prev;
        obs_t e;
        bit   have;
        have = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk_100mhz);
            if (!mon_en) begin
                have = 1'b0;
            end else begin
                cur = {state, sec_tens, sec_ones, playing, time_up};
                if (!have) begin
                    prev = cur;
                    have = 1'b1;
                end else if (cur !== prev) begin
                    prev = cur;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_update: got st=%0d digits=%0d%0d playing=%0b time_up=%0b, nothing expected",
                                 cur.st, cur.tens, cur.ones, cur.play, cur.tup);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            errors++;
                            $display("FAIL scoreboard: got st=%0d digits=%0d%0d playing=%0b time_up=%0b, expected st=%0d digits=%0d%0d playing=%0b time_up=%0b",
                                     cur.st, cur.tens, cur.ones, cur.play, cur.tup,
                                     e.st, e.tens, e.ones, e.play, e.tup);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic push_exp(input logic [2:0] st, input logic [3:0] t, input logic [3:0] o,
                            input logic p, input logic u);
        obs_t e;
        e = {st, t, o, p, u};
        exp_q.push_back(e);
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int budget;
        target = ticks_seen + n;
        budget = n * 10 + 40;
        while (ticks_seen < target && budget > 0) begin
            @(negedge clk_100mhz);
            budget--;
        end
        if (ticks_seen < target) begin
            checks++;
            errors++;
            $display("FAIL wait_ticks: got %0d ticks, expected %0d", ticks_seen, target);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk_100mhz);
    endtask

    task automatic pulse_start(input logic with_pause);
        pause = with_pause;
        start = 1'b1;
        @(negedge clk_100mhz);
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        int np;
        int nd;
        bit prev_p;

        // 1: reset with game_tick held high, then edge detection.
        reset = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        repeat (3) @(negedge clk_100mhz);
        check("reset_state", 32'(state), 32'd0);
        check("reset_tens", 32'(sec_tens), 32'd1);
        check("reset_ones", 32'(sec_ones), 32'd2);
        check("reset_tick_pulse", 32'(tick_pulse), 32'd0);
        check("reset_playing", 32'(playing), 32'd0);
        check("reset_time_up", 32'(time_up), 32'd0);
        reset = 1'b0;
        np = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_100mhz);
            if (tick_pulse) np++;
        end
        check("first_tick_after_reset", 32'(np), 32'd1);
        mon_en = 1'b1;
        gen_en = 1'b1;
        np = 0;
        nd = 0;
        prev_p = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_100mhz);
            if (tick_pulse) begin
                np++;
                if (prev_p) nd++;
            end
            prev_p = tick_pulse;
        end
        check("pulses_in_5_periods", 32'(np), 32'd5);
        check("pulse_width_overrun", 32'(nd), 32'd0);

        // 2: pre-round countdown.
        wait_ticks(1);
        settle();
        push_exp(3'd1, 4'd0, 4'd3, 1'b0, 1'b0);
        push_exp(3'd1, 4'd0, 4'd2, 1'b0, 1'b0);
        push_exp(3'd1, 4'd0, 4'd1, 1'b0, 1'b0);
        push_exp(3'd2, 4'd1, 4'd2, 1'b1, 1'b0);
        pulse_start(1'b0);
        wait_ticks(12);
        settle();
        check("play_entry_state", 32'(state), 32'd2);
        check("play_entry_playing", 32'(playing), 32'd1);

        // 3: uninterrupted play to expiry.
        for (int s = 11; s >= 1; s--) push_exp(3'd2, 4'(s / 10), 4'(s % 10), 1'b1, 1'b0);
        push_exp(3'd4, 4'd0, 4'd0, 1'b0, 1'b1);
        push_exp(3'd4, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_ticks(48);
        settle();
        check("over_state", 32'(state), 32'd4);
        check("over_playing", 32'(playing), 32'd0);
        check("over_time_up_cleared", 32'(time_up), 32'd0);

        // 4: pause at 10 with sub=2, resume keeps the partial second.
        push_exp(3'd1, 4'd0, 4'd3, 1'b0, 1'b0);
        push_exp(3'd1, 4'd0, 4'd2, 1'b0, 1'b0);
        push_exp(3'd1, 4'd0, 4'd1, 1'b0, 1'b0);
        push_exp(3'd2, 4'd1, 4'd2, 1'b1, 1'b0);
        push_exp(3'd2, 4'd1, 4'd1, 1'b1, 1'b0);
        push_exp(3'd2, 4'd1, 4'd0, 1'b1, 1'b0);
        pulse_start(1'b0);
        wait_ticks(22);
        settle();
        push_exp(3'd3, 4'd1, 4'd0, 1'b0, 1'b0);
        pause = 1'b1;
        wait_ticks(30);
        settle();
        check("paused_state", 32'(state), 32'd3);
        check("paused_digits", {24'd0, sec_tens, sec_ones}, 32'h10);
        push_exp(3'd2, 4'd1, 4'd0, 1'b1, 1'b0);
        pause = 1'b0;
        wait_ticks(1);
        settle();
        check("resume_tick1_digits", {24'd0, sec_tens, sec_ones}, 32'h10);
        push_exp(3'd2, 4'd0, 4'd9, 1'b1, 1'b0);
        wait_ticks(1);
        settle();
        check("resume_tick2_digits", {24'd0, sec_tens, sec_ones}, 32'h09);

        // 5: pause coincident with the expiring second; start with pause in OVER.
        for (int s = 8; s >= 1; s--) push_exp(3'd2, 4'd0, 4'(s), 1'b1, 1'b0);
        wait_ticks(32);
        settle();
        check("at_01_digits", {24'd0, sec_tens, sec_ones}, 32'h01);
        push_exp(3'd4, 4'd0, 4'd0, 1'b0, 1'b1);
        push_exp(3'd4, 4'd0, 4'd0, 1'b0, 1'b0);
        wait_ticks(4);
        @(negedge clk_100mhz);
        pause = 1'b1;
        @(negedge clk_100mhz);
        pause = 1'b0;
        settle();
        check("expiry_beats_pause", 32'(state), 32'd4);
        push_exp(3'd1, 4'd0, 4'd3, 1'b0, 1'b0);
        pulse_start(1'b1);
        settle();
        check("start_wins_over_pause", 32'(state), 32'd1);

        // 6: reset mid-play at 07.
        push_exp(3'd1, 4'd0, 4'd2, 1'b0, 1'b0);
        push_exp(3'd1, 4'd0, 4'd1, 1'b0, 1'b0);
        push_exp(3'd2, 4'd1, 4'd2, 1'b1, 1'b0);
        for (int s = 11; s >= 7; s--) push_exp(3'd2, 4'(s / 10), 4'(s % 10), 1'b1, 1'b0);
        wait_ticks(32);
        settle();
        check("pre_reset_digits", {24'd0, sec_tens, sec_ones}, 32'h07);
        wait_ticks(1);
        push_exp(3'd0, 4'd1, 4'd2, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk_100mhz);
        check("midreset_state", 32'(state), 32'd0);
        check("midreset_digits", {24'd0, sec_tens, sec_ones}, 32'h12);
        check("midreset_time_up", 32'(time_up), 32'd0);
        check("midreset_tick_pulse", 32'(tick_pulse), 32'd0);
        reset = 1'b0;
        settle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
